// File: rtl/goal_scorekeeper.sv
// Score keeper and round/match FSM sitting behind the ball mover; all activity advances on game ticks.
// Optional macro GOAL_FLASH_EN adds the goal-celebration blink on flash.
module goal_scorekeeper #(
  parameter int WIN_SCORE  = 7,
  parameter int HOLD_TICKS = 16,
  parameter int CLR_TICKS  = 2
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       clk_cursor,
  input  logic       collide1,
  input  logic       collide2,
  input  logic       new_game,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       round_clr,
  output logic [1:0] state,
  output logic [1:0] winner,
  output logic       flash
);

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_GOAL_HOLD = 2'd1,
    ST_ROUND_RST = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_e;

  localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);
  localparam logic [7:0] CLR_LAST  = 8'(CLR_TICKS - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  score1_q, score1_d, score2_q, score2_d;
  logic [1:0]  winner_q, winner_d;
  logic        round_clr_q, round_clr_d;
  logic        clk_cursor_q, new_game_q;
  logic        tick, ng_edge;
  logic [3:0]  score1_inc, score2_inc;

  assign tick       = ~clk_cursor_q & clk_cursor;
  assign ng_edge    = ~new_game_q & new_game;
  assign score1_inc = score1_q + 4'd1;
  assign score2_inc = score2_q + 4'd1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= ST_ROUND_RST;
      cnt_q        <= '0;
      score1_q     <= '0;
      score2_q     <= '0;
      winner_q     <= '0;
      round_clr_q  <= 1'b1;
      clk_cursor_q <= 1'b0;
      new_game_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      winner_q     <= winner_d;
      round_clr_q  <= round_clr_d;
      clk_cursor_q <= clk_cursor;
      new_game_q   <= new_game;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;
    if (ng_edge) begin
      // A restart request outranks any goal landing on the same tick.
      state_d  = ST_ROUND_RST;
      cnt_d    = '0;
      score1_d = '0;
      score2_d = '0;
      winner_d = '0;
    end else if (tick) begin
      unique case (state_q)
        ST_PLAY: begin
          if (collide1) begin
            score2_d = score2_inc;
            if (score2_inc == WIN_VAL) begin
              state_d  = ST_GAME_OVER;
              winner_d = 2'b10;
            end else begin
              state_d = ST_GOAL_HOLD;
            end
          end else if (collide2) begin
            score1_d = score1_inc;
            if (score1_inc == WIN_VAL) begin
              state_d  = ST_GAME_OVER;
              winner_d = 2'b01;
            end else begin
              state_d = ST_GOAL_HOLD;
            end
          end
        end
        ST_GOAL_HOLD: begin
          if (cnt_q == HOLD_LAST) state_d = ST_ROUND_RST;
          else                    cnt_d   = cnt_q + 8'd1;
        end
        ST_ROUND_RST: begin
          // Once the clear has lasted long enough, wait for the mover to report both goals empty.
          if (cnt_q >= CLR_LAST) begin
            if (!collide1 && !collide2) state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_GAME_OVER: ;
        default: ;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
  end

  // Registered so the mover's asynchronous clear never sees a glitch.
  always_comb begin
    round_clr_d = (state_d == ST_ROUND_RST) || (state_d == ST_GAME_OVER);
  end

`ifdef GOAL_FLASH_EN
  logic flash_q, flash_d;

  always_comb begin
    flash_d = 1'b0;
    if (state_d == ST_GOAL_HOLD) begin
      if (state_q != ST_GOAL_HOLD) flash_d = 1'b1;
      else if (tick)               flash_d = ~flash_q;
      else                         flash_d = flash_q;
    end else if (state_d == ST_GAME_OVER) begin
      flash_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) flash_q <= 1'b0;
    else        flash_q <= flash_d;
  end

  assign flash = flash_q;
`else
  assign flash = 1'b0;
`endif

  assign state     = state_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign winner    = winner_q;
  assign round_clr = round_clr_q;

endmodule

// File: tb/tb_goal_scorekeeper.sv
// Scoreboard bench for goal_scorekeeper: a tick-level model queues expected outputs per step.
module tb_goal_scorekeeper;

  localparam int WIN  = 7;
  localparam int HOLD = 16;
  localparam int CLRT = 2;

  localparam logic [1:0] S_PLAY = 2'd0, S_GH = 2'd1, S_RR = 2'd2, S_GO = 2'd3;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       clk_cursor = 1'b0;
  logic       collide1 = 1'b0;
  logic       collide2 = 1'b0;
  logic       new_game = 1'b0;
  logic [3:0] score1, score2;
  logic       round_clr;
  logic [1:0] state, winner;
  logic       flash;

  goal_scorekeeper #(.WIN_SCORE(WIN), .HOLD_TICKS(HOLD), .CLR_TICKS(CLRT)) dut (
    .clk(clk), .clr_n(clr_n), .clk_cursor(clk_cursor), .collide1(collide1),
    .collide2(collide2), .new_game(new_game), .score1(score1), .score2(score2),
    .round_clr(round_clr), .state(state), .winner(winner), .flash(flash)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] win;
    logic       rc;
    logic       fl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Tick-level reference model
  logic [1:0] m_st;
  logic [3:0] m_s1, m_s2;
  logic [1:0] m_win;
  int         m_ticks;
  logic       m_fl;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_RR; m_s1 = 0; m_s2 = 0; m_win = 0; m_ticks = 0; m_fl = 0;
  endtask

  task automatic model_step(input logic tk, input logic ng, input logic c1, input logic c2);
    logic [1:0] prev;
    prev = m_st;
    if (ng) begin
      m_st = S_RR; m_s1 = 0; m_s2 = 0; m_win = 0; m_ticks = 0;
    end else if (tk) begin
      case (m_st)
        S_PLAY: begin
          if (c1) begin
            m_s2 = m_s2 + 1;
            if (m_s2 == WIN) begin m_st = S_GO; m_win = 2'b10; end
            else m_st = S_GH;
            m_ticks = 0;
          end else if (c2) begin
            m_s1 = m_s1 + 1;
            if (m_s1 == WIN) begin m_st = S_GO; m_win = 2'b01; end
            else m_st = S_GH;
            m_ticks = 0;
          end
        end
        S_GH: begin
          m_ticks++;
          if (m_ticks == HOLD) begin m_st = S_RR; m_ticks = 0; end
        end
        S_RR: begin
          if (m_ticks < CLRT) m_ticks++;
          if (m_ticks >= CLRT && !c1 && !c2) begin m_st = S_PLAY; m_ticks = 0; end
        end
        default: ;
      endcase
    end
`ifdef GOAL_FLASH_EN
    if (m_st == S_GH) m_fl = (prev != S_GH) ? 1'b1 : (tk ? ~m_fl : m_fl);
    else              m_fl = (m_st == S_GO);
`else
    m_fl = 1'b0;
    if (prev == 2'd0 && 1'b0) m_fl = 1'b1;
`endif
  endtask

  function automatic exp_t model_snap();
    exp_t e;
    e.st = m_st; e.s1 = m_s1; e.s2 = m_s2; e.win = m_win;
    e.rc = (m_st == S_RR) || (m_st == S_GO);
    e.fl = m_fl;
    return e;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 8'd0, 8'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_state"}, {6'd0, state}, {6'd0, e.st});
    check({tag, "_score1"}, {4'd0, score1}, {4'd0, e.s1});
    check({tag, "_score2"}, {4'd0, score2}, {4'd0, e.s2});
    check({tag, "_winner"}, {6'd0, winner}, {6'd0, e.win});
    check({tag, "_round_clr"}, {7'd0, round_clr}, {7'd0, e.rc});
    check({tag, "_flash"}, {7'd0, flash}, {7'd0, e.fl});
  endtask

  // One stimulus step: drive at a falling edge, the DUT reacts on the next rising edge, compare after it.
  task automatic step(input string tag, input logic tk, input logic ng, input logic c1, input logic c2);
    @(negedge clk);
    clk_cursor = tk; new_game = ng; collide1 = c1; collide2 = c2;
    model_step(tk, ng, c1, c2);
    exp_q.push_back(model_snap());
    @(negedge clk);
    compare_out(tag);
    clk_cursor = 1'b0; new_game = 1'b0;
  endtask

  task automatic ticks(input string tag, input int n, input logic c1, input logic c2);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, c1, c2);
  endtask

  // Goal, full hold, clear phase back to PLAY.
  task automatic full_goal(input string tag, input logic c1, input logic c2);
    step(tag, 1'b1, 1'b0, c1, c2);
    ticks({tag, "_hold"}, HOLD, c1, c2);
    ticks({tag, "_rr"}, CLRT, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, {6'd0, state}, {6'd0, S_RR});
    check({tag, "_score1"}, {4'd0, score1}, 8'd0);
    check({tag, "_score2"}, {4'd0, score2}, 8'd0);
    check({tag, "_winner"}, {6'd0, winner}, 8'd0);
    check({tag, "_round_clr"}, {7'd0, round_clr}, 8'd1);
    check({tag, "_flash"}, {7'd0, flash}, 8'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    clr_n = 1'b1;

    // Leave reset: two clear ticks, then PLAY.
    step("rr1", 1'b1, 1'b0, 1'b0, 1'b0);
    check("rr1_still_clr", {7'd0, round_clr}, 8'd1);
    step("rr2", 1'b1, 1'b0, 1'b0, 1'b0);
    check("rr2_play", {6'd0, state}, {6'd0, S_PLAY});

    // Non-tick cycles must not advance anything.
    step("idle", 1'b0, 1'b0, 1'b1, 1'b0);

    // Player 1 scores; collide2 held through hold and clear.
    step("p1_goal", 1'b1, 1'b0, 1'b0, 1'b1);
    check("p1_goal_score1", {4'd0, score1}, 8'd1);
    ticks("hold_c2", HOLD, 1'b0, 1'b1);
    check("hold_done_rr", {6'd0, state}, {6'd0, S_RR});
    ticks("rr_blocked", 4, 1'b0, 1'b1);
    check("rr_blocked_state", {6'd0, state}, {6'd0, S_RR});
    step("rr_release", 1'b1, 1'b0, 1'b0, 1'b0);
    check("rr_release_play", {6'd0, state}, {6'd0, S_PLAY});

    // Both flags on one tick: only player 2 gets the point.
    full_goal("both", 1'b1, 1'b1);
    check("both_score2", {4'd0, score2}, 8'd1);
    check("both_score1", {4'd0, score1}, 8'd1);

    // Player 2 runs up to six, then the seventh ends the match.
    for (int g = 0; g < 5; g++) full_goal("p2_run", 1'b1, 1'b0);
    step("p2_win", 1'b1, 1'b0, 1'b1, 1'b0);
    check("p2_win_state", {6'd0, state}, {6'd0, S_GO});
    check("p2_win_winner", {6'd0, winner}, 8'h2);
    check("p2_win_score2", {4'd0, score2}, 8'd7);
    ticks("game_over_c1", 3, 1'b1, 1'b0);
    ticks("game_over_c2", 3, 1'b0, 1'b1);
    check("frozen_score2", {4'd0, score2}, 8'd7);

    // Restart from GAME_OVER.
    step("ng_over", 1'b0, 1'b1, 1'b0, 1'b0);
    check("ng_over_state", {6'd0, state}, {6'd0, S_RR});
    ticks("ng_over_rr", CLRT, 1'b0, 1'b0);

    // Mid-match restart while holding after player 1's third point.
    full_goal("p1a", 1'b0, 1'b1);
    full_goal("p1b", 1'b0, 1'b1);
    step("p1c", 1'b1, 1'b0, 1'b0, 1'b1);
    ticks("p1c_hold", 3, 1'b0, 1'b1);
    check("p1c_score1", {4'd0, score1}, 8'd3);
    step("ng_hold", 1'b0, 1'b1, 1'b0, 1'b1);
    check("ng_hold_score1", {4'd0, score1}, 8'd0);
    ticks("ng_hold_rr", CLRT, 1'b0, 1'b0);

    // Restart coincident with a goal tick: no point awarded.
    step("ng_goal", 1'b1, 1'b1, 1'b1, 1'b0);
    check("ng_goal_score2", {4'd0, score2}, 8'd0);
    ticks("ng_goal_rr", CLRT, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a hold.
    step("pre_rst_goal", 1'b1, 1'b0, 1'b0, 1'b1);
    ticks("pre_rst_hold", 3, 1'b0, 1'b1);
    @(negedge clk);
    collide2 = 1'b0;
    #2 clr_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    check_reset_values("rst_held");
    clr_n = 1'b1;
    ticks("post_rst", CLRT, 1'b0, 1'b0);
    check("post_rst_play", {6'd0, state}, {6'd0, S_PLAY});
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
